// File: rtl/frame_out_sched.sv
// Frame FIFO read-side sequencer: pops descriptor + payload, drops bad frames, dispatches to the serializers.
// Optional macro SCHED_TIMEOUT_EN bounds the DISPATCH wait to TIMEOUT_CYC cycles.
module frame_out_sched #(
  parameter int CNT_W       = 16,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic               clk_out,
  input  logic               rst_n,
  input  logic               fifo_empty,
  output logic               fifo_rd_en,
  input  logic [15:0]        fifo_rdata,
  input  logic [7:0]         ser_busy,
  output logic               ser_load,
  output logic [7:0]         ser_ch,
  output logic [7:0]         ser_len,
  output logic [127:0]       ser_data,
  output logic               frame_done,
  output logic               frame_drop,
  output logic [CNT_W-1:0]   done_cnt,
  output logic [CNT_W-1:0]   drop_cnt,
  output logic               timeout_flag,
  output logic               sched_idle
);

  typedef enum logic [2:0] {S_IDLE, S_DESC, S_DATA, S_DROP, S_DISPATCH} state_t;

  state_t         state, state_nxt;
  logic [7:0]     ch_r;
  logic [4:0]     n_r;
  logic [4:0]     pops_left;
  logic [4:0]     rets_left;
  logic           rd_pending;
  logic [127:0]   buf_r;

  logic [7:0]     desc_ch;
  logic [4:0]     desc_n;
  logic           desc_ok;
  logic           tgt_busy;
  logic           last_ret;
  logic           timeout_hit;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == {CNT_W{1'b1}}) ? c : c + 1'b1;
  endfunction

  // Word counts above 8 are still fully popped to keep the FIFO aligned; length clamps at 128.
  function automatic logic [7:0] len_of(input logic [4:0] n);
    return (n > 5'd8) ? 8'd128 : {n[3:0], 4'b0000};
  endfunction

  assign desc_ch  = fifo_rdata[15:8];
  assign desc_n   = {1'b0, fifo_rdata[7:4]} + 5'd1;
  assign desc_ok  = fifo_rdata[0] && (desc_ch != 8'd0) && ((desc_ch & (desc_ch - 8'd1)) == 8'd0);
  assign tgt_busy = |(ser_busy & ch_r);
  assign last_ret = rd_pending && (rets_left == 5'd1);
  assign sched_idle = (state == S_IDLE);

`ifdef SCHED_TIMEOUT_EN
  localparam int WAIT_W = $clog2(TIMEOUT_CYC + 1);
  logic [WAIT_W-1:0] wait_cnt;
  assign timeout_hit = (state == S_DISPATCH) && tgt_busy && (wait_cnt == WAIT_W'(TIMEOUT_CYC - 1));
`else
  assign timeout_hit  = 1'b0;
  assign timeout_flag = 1'b0;
`endif

  always_ff @(posedge clk_out) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // The first payload word is popped in DESC already, before the descriptor is judged.
  always_comb begin
    state_nxt  = state;
    fifo_rd_en = 1'b0;
    case (state)
      S_IDLE: begin
        if (!fifo_empty) begin
          fifo_rd_en = 1'b1;
          state_nxt  = S_DESC;
        end
      end
      S_DESC: begin
        fifo_rd_en = !fifo_empty;
        state_nxt  = desc_ok ? S_DATA : S_DROP;
      end
      S_DATA: begin
        fifo_rd_en = (pops_left != 5'd0) && !fifo_empty;
        if (last_ret) state_nxt = S_DISPATCH;
      end
      S_DROP: begin
        fifo_rd_en = (pops_left != 5'd0) && !fifo_empty;
        if (last_ret) state_nxt = S_IDLE;
      end
      S_DISPATCH: begin
        if (!tgt_busy || timeout_hit) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    if (!rst_n) fifo_rd_en = 1'b0;
  end

  always_ff @(posedge clk_out) begin
    if (!rst_n) begin
      ch_r       <= '0;
      n_r        <= '0;
      pops_left  <= '0;
      rets_left  <= '0;
      rd_pending <= 1'b0;
      buf_r      <= '0;
      ser_load   <= 1'b0;
      ser_ch     <= '0;
      ser_len    <= '0;
      ser_data   <= '0;
      frame_done <= 1'b0;
      frame_drop <= 1'b0;
      done_cnt   <= '0;
      drop_cnt   <= '0;
`ifdef SCHED_TIMEOUT_EN
      wait_cnt     <= '0;
      timeout_flag <= 1'b0;
`endif
    end else begin
      ser_load   <= 1'b0;
      frame_done <= 1'b0;
      frame_drop <= 1'b0;
      rd_pending <= fifo_rd_en;
      case (state)
        S_DESC: begin
          ch_r      <= desc_ch;
          n_r       <= desc_n;
          rets_left <= desc_n;
          pops_left <= desc_n - {4'd0, fifo_rd_en};
          buf_r     <= '0;
        end
        S_DATA: begin
          if (fifo_rd_en) pops_left <= pops_left - 5'd1;
          if (rd_pending) begin
            buf_r     <= {buf_r[111:0], fifo_rdata};
            rets_left <= rets_left - 5'd1;
          end
`ifdef SCHED_TIMEOUT_EN
          if (last_ret) wait_cnt <= '0;
`endif
        end
        S_DROP: begin
          if (fifo_rd_en) pops_left <= pops_left - 5'd1;
          if (rd_pending) begin
            rets_left <= rets_left - 5'd1;
            if (rets_left == 5'd1) begin
              frame_drop <= 1'b1;
              drop_cnt   <= sat_inc(drop_cnt);
            end
          end
        end
        S_DISPATCH: begin
          if (!tgt_busy) begin
            ser_load   <= 1'b1;
            ser_ch     <= ch_r;
            ser_len    <= len_of(n_r);
            ser_data   <= buf_r;
            frame_done <= 1'b1;
            done_cnt   <= sat_inc(done_cnt);
          end else if (timeout_hit) begin
            frame_drop <= 1'b1;
            drop_cnt   <= sat_inc(drop_cnt);
`ifdef SCHED_TIMEOUT_EN
            timeout_flag <= 1'b1;
`endif
          end
`ifdef SCHED_TIMEOUT_EN
          if (tgt_busy) wait_cnt <= wait_cnt + 1'b1;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/frame_out_sched.md
Name: frame_out_sched

Overview:
- Read-side sequencer for the frame path, in the clk_out domain.
- Pops frame records (descriptor word + payload words) from the frame FIFO and assembles the payload into a 128-bit buffer.
- Drops frames whose CRC failed or whose channel field is invalid; otherwise dispatches the frame to the per-channel serializer once that channel is idle.
- Sits between the async frame FIFO read port and the 8 Gray-code serializers.

Parameters:
- CNT_W, 16, width of the drop/done statistics counters; counters saturate at all-ones.
- TIMEOUT_CYC, 1024, maximum DISPATCH wait in cycles; used only when SCHED_TIMEOUT_EN is defined.

Ports:
- clk_out  in  1  system clock for this block; one clock only.
- rst_n  in  1  reset; synchronous, active-low.
- fifo_empty  in  1  frame FIFO empty flag.
- fifo_rd_en  out  1  FIFO pop; fifo_rdata is valid the cycle after.
- fifo_rdata  in  16  FIFO read data.
- ser_busy  in  8  per-channel serializer busy; bit i = channel i+1.
- ser_load  out  1  one-cycle dispatch strobe.
- ser_ch  out  8  one-hot target channel; valid with ser_load.
- ser_len  out  8  payload bits (16..128, multiple of 16); valid with ser_load.
- ser_data  out  128  payload, right-justified, first received word most significant.
- frame_done  out  1  one-cycle pulse per dispatched frame.
- frame_drop  out  1  one-cycle pulse per dropped frame.
- done_cnt  out  CNT_W  saturating count of dispatched frames.
- drop_cnt  out  CNT_W  saturating count of dropped frames.
- timeout_flag  out  1  sticky; set when a dispatch times out.
- sched_idle  out  1  high when the FSM is in IDLE.

Behaviour:
- Reset (rst_n low at a clk_out edge) sets:
  - FSM to IDLE; sched_idle=1.
  - All pulses, ser_ch, ser_len, ser_data and the buffer to 0; counters to 0; timeout_flag to 0.
- Reset mid-frame abandons any partly read record. The FIFO must be reset in the same window.
- Descriptor word format:
  - [15:8] channel, one-hot.
  - [7:4] word count minus 1 (N = 1..8 payload words).
  - [3:1] reserved, ignored.
  - [0] crc_ok.
- fifo_rd_en is asserted only when fifo_empty=0. An empty FIFO mid-record stalls the FSM; it never aborts.
- States and transitions:
  - IDLE: if !fifo_empty, pop the descriptor and go to DESC.
  - DESC: capture the descriptor. Invalid if the channel field is not exactly one bit set, i.e. zero or multi-hot. If crc_ok=0 or invalid, go to DROP; otherwise go to DATA. Word counter = N.
  - DATA: pop one word per cycle while the FIFO is non-empty. Each returned word: buf <= {buf[111:0], word}. Upper bits are cleared at DESC. After N words have returned, go to DISPATCH.
  - DROP: pop and discard N words with the same stall rules. After the last word returns: pulse frame_drop, increment drop_cnt, go to IDLE.
  - DISPATCH: when ser_busy & ch == 0, assert ser_load for 1 cycle with ser_ch/ser_len(=16*N)/ser_data, pulse frame_done, increment done_cnt, go to IDLE. ser_ch/ser_len/ser_data hold until the next load.
- Latency: with a non-empty FIFO and idle serializer, ser_load asserts N+3 cycles after the descriptor pop.
- The serializer must raise busy within 1 cycle of ser_load. The next dispatch is at least 3 cycles later.
- A busy change on a non-target channel has no effect. A busy bit that drops in the same cycle DISPATCH is entered is honoured that cycle.
- Counters saturate at all-ones; they never wrap.

Optional Feature:
- Macro: SCHED_TIMEOUT_EN.
- Defined:
  - A wait counter clears on DISPATCH entry and increments each cycle the target stays busy.
  - On reaching TIMEOUT_CYC, the frame is discarded: no ser_load, frame_drop pulses, drop_cnt increments, timeout_flag set (sticky until reset), FSM goes to IDLE.
- Undefined: DISPATCH waits indefinitely; timeout_flag is tied 0.

Test Plan:
- Descriptor 16'h0101 (ch1, N=1, ok), word A55A, busy=0 -> ser_load after 4 cycles; ser_ch=01, ser_len=16, ser_data=...A55A; done_cnt=1.
- Descriptor 16'h0271 (ch2, N=8, ok), words 0123,4567,...,3210 -> ser_len=128, ser_data=0123456789ABCDEFFEDCBA9876543210.
- Descriptor 16'h0110 (crc_ok=0, N=2) followed by a valid ch3 frame -> frame_drop pulse, drop_cnt=1, 2 words discarded; the ch3 frame then dispatches correctly.
- Descriptors 16'h0001 and 16'h0301 (zero and multi-hot channel) -> both dropped, drop_cnt=2, no ser_load.
- fifo_empty toggled every other cycle during an N=4 payload; ser_busy[4]=1 for 20 cycles -> no pops while empty, payload intact, ser_load in the cycle busy falls.
- SCHED_TIMEOUT_EN with TIMEOUT_CYC=8, ser_busy[0] stuck high -> frame_drop at cycle 8 of DISPATCH, timeout_flag=1. Mid-DATA rst_n=0 for 1 cycle -> all outputs 0, sched_idle=1.
